demux_stream_n: RTL

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes. Each input beat is routed to the output channel selected by `sel` and held in a one-entry register for that channel until the sink accepts it. Backpressure is per channel, and beats addressed to non-existent channels are dropped and counted. This block is the streaming successor to the combinational enable-gated demux, used wherever a data path fans out to several independently stalling consumers.

---
 rtl/demux_stream_n.sv | 83 ++++++++
 1 files changed

// File: rtl/demux_stream_n.sv
// Registered 1-to-N stream demultiplexer: each channel holds at most one beat
// until its sink accepts it. Beats aimed past the last channel are dropped and counted.
module demux_stream_n #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] m_data,
  output logic [NUM_CH-1:0]            m_valid,
  input  logic [NUM_CH-1:0]            m_ready,
  output logic [15:0]                  drop_cnt
);

  localparam logic [SEL_WIDTH:0] NUM_CH_W = NUM_CH[SEL_WIDTH:0];

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_q;
  logic [NUM_CH-1:0]                 valid_q;
  logic [15:0]                       drop_q;

  logic              sel_ok;
  logic              sel_busy;
  logic              acc;
  logic              drop;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;

  assign sel_ok = ({1'b0, sel} < NUM_CH_W);

  // Decode by comparison so an out-of-range sel never indexes past the arrays.
  always_comb begin
    sel_busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_busy = valid_q[k] & ~m_ready[k];
      end
    end
  end

  assign s_ready = en & ~(sel_ok & sel_busy);
  assign acc     = s_valid & s_ready;
  assign drop    = acc & ~sel_ok;

  always_comb begin
    load  = '0;
    drain = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k]  = acc & sel_ok & (sel == SEL_WIDTH'(k));
      drain[k] = valid_q[k] & m_ready[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      drop_q  <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) begin
          data_q[k]  <= s_data;
          valid_q[k] <= 1'b1;
        end else if (drain[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign drop_cnt = drop_q;

endmodule
